// File: rtl/psum_writeback.sv
// psum_writeback
//   Drains a convolution partial-sum buffer. For every valid output pixel it
//   reads one buffer word (ARRAY_DIM signed ACC_WIDTH psums). The buffer uses
//   a strided layout, with word address oy*input_w + ox. Each psum is
//   requantised to a signed DATA_WIDTH value (optional ReLU, rounding
//   arithmetic right shift, saturation). The block then emits one beat on a
//   valid/ready port, with out_addr as the dense pixel index oy*OUT_W + ox.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start / busy / done        drain request, drain in progress, completion pulse
//   kernel_h, kernel_w         kernel size (latched on start)
//   input_h, input_w           input feature-map size (latched on start)
//   shift, relu_en             requantisation controls (latched on start)
//   buf_rd_en/addr/data        buffer read port; data is expected one cycle after the strobe
//   out_valid/ready            output beat handshake
//   out_addr, out_data         dense pixel index and requantised channels
module psum_writeback #(
  parameter int ARRAY_DIM  = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int BUF_AW     = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic [3:0]                      kernel_h,
  input  logic [3:0]                      kernel_w,
  input  logic [7:0]                      input_h,
  input  logic [7:0]                      input_w,
  input  logic [4:0]                      shift,
  input  logic                            relu_en,
  output logic                            buf_rd_en,
  output logic [BUF_AW-1:0]               buf_rd_addr,
  input  logic [ARRAY_DIM*ACC_WIDTH-1:0]  buf_rd_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [15:0]                     out_addr,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] out_data
);

  typedef enum logic [2:0] {IDLE, RD, CAP, OUT, FIN} state_t;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2**(DATA_WIDTH-1)));

  state_t state_reg, state_next;

  logic [3:0]                      kw_reg;
  logic [7:0]                      out_w_reg, out_h_reg;
  logic [4:0]                      shift_reg;
  logic                            relu_reg;
  logic [7:0]                      ox_reg, oy_reg;
  logic [BUF_AW-1:0]               rd_addr_reg;
  logic [15:0]                     pix_reg;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] out_data_reg;
  logic [ARRAY_DIM*DATA_WIDTH-1:0] quant_all;

  logic cfg_ok, last_x, last_y, last_pix;

  // A zero-sized kernel or one larger than the input yields no output pixels.
  assign cfg_ok = (kernel_h != 4'd0) && (kernel_w != 4'd0) &&
                  ({4'd0, kernel_h} <= input_h) && ({4'd0, kernel_w} <= input_w);

  assign last_x   = (ox_reg == out_w_reg - 8'd1);
  assign last_y   = (oy_reg == out_h_reg - 8'd1);
  assign last_pix = last_x && last_y;

  // Requantisation, one lane per channel.
  for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_ch
    logic signed [ACC_WIDTH-1:0] psum;
    logic signed [ACC_WIDTH:0]   ext, rnd, shifted;

    assign psum    = buf_rd_data[gi*ACC_WIDTH +: ACC_WIDTH];
    assign ext     = (relu_reg && psum[ACC_WIDTH-1]) ? '0 : {psum[ACC_WIDTH-1], psum};
    // One extra bit of headroom keeps the rounding add from overflowing.
    assign rnd     = (shift_reg == 5'd0) ? ext
                                         : ext + ((ACC_WIDTH+1)'(1) << (shift_reg - 5'd1));
    assign shifted = rnd >>> shift_reg;
    assign quant_all[gi*DATA_WIDTH +: DATA_WIDTH] =
        (shifted > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
        (shifted < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                              shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = (state_reg == FIN);
    buf_rd_en  = (state_reg == RD);
    out_valid  = (state_reg == OUT);
    case (state_reg)
      IDLE: if (start) state_next = cfg_ok ? RD : FIN;
      RD:   state_next = CAP;
      CAP:  state_next = OUT;
      OUT:  if (out_ready) state_next = last_pix ? FIN : RD;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: configuration latch, raster counters and the output holding register.
  // The buffer address is advanced incrementally. At a row end, the step from
  // (oy, OUT_W-1) to (oy+1, 0) in the strided layout is input_w - OUT_W + 1,
  // which equals kernel_w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kw_reg       <= '0;
      out_w_reg    <= '0;
      out_h_reg    <= '0;
      shift_reg    <= '0;
      relu_reg     <= 1'b0;
      ox_reg       <= '0;
      oy_reg       <= '0;
      rd_addr_reg  <= '0;
      pix_reg      <= '0;
      out_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            kw_reg      <= kernel_w;
            out_w_reg   <= input_w - {4'd0, kernel_w} + 8'd1;
            out_h_reg   <= input_h - {4'd0, kernel_h} + 8'd1;
            shift_reg   <= shift;
            relu_reg    <= relu_en;
            ox_reg      <= '0;
            oy_reg      <= '0;
            rd_addr_reg <= '0;
            pix_reg     <= '0;
          end
        end
        CAP: out_data_reg <= quant_all;
        OUT: begin
          if (out_ready && !last_pix) begin
            pix_reg <= pix_reg + 16'd1;
            if (last_x) begin
              ox_reg      <= '0;
              oy_reg      <= oy_reg + 8'd1;
              rd_addr_reg <= rd_addr_reg + BUF_AW'(kw_reg);
            end else begin
              ox_reg      <= ox_reg + 8'd1;
              rd_addr_reg <= rd_addr_reg + BUF_AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign buf_rd_addr = rd_addr_reg;
  assign out_addr    = pix_reg;
  assign out_data    = out_data_reg;

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback. The bench acts as the partial-sum
// buffer, with one cycle of read latency. Each drain is expanded by a
// reference model into the expected read addresses and output beats. The
// expected values go into queues, and a negedge monitor pops and compares
// them as the DUT produces them.
module tb_psum_writeback;
  localparam int DIM = 4;
  localparam int AW  = 32;
  localparam int DW  = 8;
  localparam int BAW = 10;

  logic              clk, rst_n, start, busy, done;
  logic [3:0]        kernel_h, kernel_w;
  logic [7:0]        input_h, input_w;
  logic [4:0]        shift;
  logic              relu_en, buf_rd_en, out_valid, out_ready;
  logic [BAW-1:0]    buf_rd_addr;
  logic [DIM*AW-1:0] buf_rd_data;
  logic [15:0]       out_addr;
  logic [DIM*DW-1:0] out_data;

  psum_writeback #(.ARRAY_DIM(DIM), .ACC_WIDTH(AW), .DATA_WIDTH(DW), .BUF_AW(BAW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .kernel_h(kernel_h), .kernel_w(kernel_w), .input_h(input_h), .input_w(input_w),
    .shift(shift), .relu_en(relu_en),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DIM*AW-1:0] mem [0:(1<<BAW)-1];
  int                rd_q[$];
  int                exp_addr_q[$];
  logic [DIM*DW-1:0] exp_data_q[$];
  int                n_cmp = 0, n_err = 0;
  int                beats_seen = 0, done_cnt = 0, cur_limit = 0;
  bit                rdy_rand = 1'b0;
  logic [DIM*DW-1:0] last_data = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Reference requantisation in plain 64-bit arithmetic.
  function automatic int rq(input logic [AW-1:0] raw, input int sh, input bit relu);
    longint v;
    v = longint'($signed(raw));
    if (relu && v < 0) v = 0;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic logic [DIM*DW-1:0] expect_word(input logic [DIM*AW-1:0] w, input int sh, input bit relu);
    logic [DIM*DW-1:0] r;
    int q;
    r = '0;
    for (int c = 0; c < DIM; c++) begin
      q = rq(w[c*AW +: AW], sh, relu);
      r[c*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  task automatic fill_mem();
    int v;
    for (int i = 0; i < (1 << BAW); i++) begin
      for (int c = 0; c < DIM; c++) begin
        case ($urandom_range(0, 2))
          0:       v = int'($urandom);
          1:       v = int'($urandom_range(0, 800)) - 400;
          default: v = int'($urandom_range(0, 100000)) - 50000;
        endcase
        mem[i][c*AW +: AW] = v;
      end
    end
  endtask

  // Expand one drain into expected reads and beats. Returns the pixel count.
  task automatic push_model(input int kh, kw, ih, iw, sh, input bit relu, output int n);
    int oh, ow, a;
    n = 0;
    cur_limit = ih * iw;
    if (kh > 0 && kw > 0 && kh <= ih && kw <= iw) begin
      oh = ih - kh + 1;
      ow = iw - kw + 1;
      for (int y = 0; y < oh; y++) begin
        for (int x = 0; x < ow; x++) begin
          a = y * iw + x;
          rd_q.push_back(a);
          exp_addr_q.push_back(y * ow + x);
          exp_data_q.push_back(expect_word(mem[a], sh, relu));
        end
      end
      n = oh * ow;
    end
  endtask

  task automatic set_cfg(input int kh, kw, ih, iw, sh, input bit relu);
    kernel_h = 4'(kh);
    kernel_w = 4'(kw);
    input_h  = 8'(ih);
    input_w  = 8'(iw);
    shift    = 5'(sh);
    relu_en  = relu;
  endtask

  task automatic drain(input int kh, kw, ih, iw, sh, input bit relu,
                       input bit rnd_ready, input bit inject, input bit check_dur);
    int n, j, b0, d0;
    push_model(kh, kw, ih, iw, sh, relu, n);
    b0 = beats_seen;
    d0 = done_cnt;
    rdy_rand = rnd_ready;
    @(posedge clk); #1;
    set_cfg(kh, kw, ih, iw, sh, relu);
    start = 1'b1;
    j = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      j++;
      // A second start with a different configuration while busy must be ignored.
      if (inject && n >= 4 && j == 4) begin
        set_cfg($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(1, 255),
                $urandom_range(1, 255), $urandom_range(0, 31), 1'($urandom));
        start = 1'b1;
      end
    end while (!done && j < 20000);
    check("done_seen", done, 1);
    if (check_dur) check("duration", j + 1, 3 * n + 2);
    @(negedge clk); #1;
    check("beat_count", beats_seen - b0, n);
    check("done_count", done_cnt - d0, 1);
    check("rd_left", rd_q.size(), 0);
    check("beats_left", exp_addr_q.size(), 0);
    @(posedge clk); #1;
    check("idle_after", busy, 0);
    $display("drain k=%0dx%0d in=%0dx%0d shift=%0d relu=%0d pixels=%0d cycles=%0d",
             kh, kw, ih, iw, sh, relu, n, j + 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, buf_rd_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_rd_addr"}, buf_rd_addr, 0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic reset_mid_drain();
    int n, j, b0, d0;
    push_model(3, 3, 8, 8, 2, 1'b0, n);
    b0 = beats_seen;
    rdy_rand = 1'b0;
    @(posedge clk); #1;
    set_cfg(3, 3, 8, 8, 2, 1'b0);
    start = 1'b1;
    j = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      j++;
    end while (!((beats_seen - b0) == 10 && out_valid) && j < 5000);
    check("abort_point", beats_seen - b0, 10);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    rd_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt - d0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_stay_idle", busy, 0);
    $display("reset applied during beat 10 of %0d", n);
  endtask

  // Sink ready: held high or toggled pseudo-randomly.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Buffer model: data appears one cycle after the read strobe and is scrambled afterwards.
  initial begin
    int a;
    buf_rd_data = '0;
    forever begin
      @(negedge clk);
      if (buf_rd_en && rst_n) begin
        a = int'(buf_rd_addr);
        @(posedge clk); #1;
        buf_rd_data = mem[a];
        @(posedge clk); #1;
        buf_rd_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor and scoreboard.
  initial begin
    bit                prev_stall;
    logic [15:0]       prev_addr;
    logic [DIM*DW-1:0] prev_data;
    int                ea;
    logic [DIM*DW-1:0] ed;
    prev_stall = 1'b0;
    prev_addr  = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (buf_rd_en) begin
          if (rd_q.size() == 0) fail_now("rd_unexpected", buf_rd_addr);
          else begin
            ea = rd_q.pop_front();
            check("rd_addr", buf_rd_addr, ea);
            check("rd_in_range", int'(buf_rd_addr) < cur_limit, 1);
          end
        end
        if (prev_stall) begin
          check("stall_valid", out_valid, 1);
          check("stall_addr", out_addr, prev_addr);
          check("stall_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (exp_addr_q.size() == 0) fail_now("beat_unexpected", out_addr);
          else begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("beat_addr", out_addr, ea);
            check("beat_data", out_data, ed);
          end
          $display("beat addr=%0d data=0x%08h", out_addr, out_data);
          beats_seen++;
          last_data = out_data;
        end
        if (done) done_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_addr  = out_addr;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 1'b0);
    fill_mem();
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // 8x8 input, 3x3 kernel, sink always ready.
    drain(3, 3, 8, 8, 4, 1'b0, 1'b0, 1'b0, 1'b1);

    // Requantisation corner values on a single pixel.
    mem[0] = {32'hFFFF_FED4, 32'd3, 32'hFFFF_FFFB, 32'd300};
    drain(1, 1, 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("requant_shift", last_data, 32'h8002_FE7F);
    mem[0] = {32'd0, 32'd0, 32'd42, 32'hFFFF_FFF9};
    drain(1, 1, 1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("requant_relu", last_data, 32'h0000_2A00);

    // Back-pressure with an ignored start while busy.
    fill_mem();
    drain(3, 3, 8, 8, $urandom_range(0, 31), 1'($urandom), 1'b1, 1'b1, 1'b0);

    // Kernel taller than the input: straight to done.
    drain(9, 3, 8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain(0, 2, 8, 8, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a drain, then a clean restart.
    reset_mid_drain();
    drain(3, 3, 8, 8, 3, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random configurations.
    for (int t = 0; t < 12; t++) begin
      fill_mem();
      drain($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 16),
            $urandom_range(1, 16), $urandom_range(0, 31), 1'($urandom),
            1'($urandom), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_writeback.md
PSUM_WRITEBACK -- requirements
Module: psum_writeback

Interface
REQ-001 The block SHALL have parameter ARRAY_DIM, default 16, giving the number of output channels per buffer word.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32, giving the signed width of each partial sum.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 8, giving the signed width of each output element.
REQ-004 The block SHALL have parameter BUF_AW, default 10, giving the partial-sum buffer address width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle drain request
- busy  out  1  drain in progress
- done  out  1  single-cycle completion pulse
- kernel_h, kernel_w  in  4 each  kernel size
- input_h, input_w  in  8 each  input feature-map size
- shift  in  5  right-shift amount for requantisation
- relu_en  in  1  clamp negatives to zero
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  BUF_AW  buffer word address
- buf_rd_data  in  ARRAY_DIM*ACC_WIDTH  buffer word; channel c is at bits [c*ACC_WIDTH +: ACC_WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  sink accepts beat
- out_addr  out  16  dense output pixel index
- out_data  out  ARRAY_DIM*DATA_WIDTH  requantised channels; channel c is at bits [c*DATA_WIDTH +: DATA_WIDTH]

Function
REQ-006 On start in IDLE, the block SHALL latch kernel_h, kernel_w, input_h, input_w, shift and relu_en, and SHALL compute OUT_H = input_h-kernel_h+1 and OUT_W = input_w-kernel_w+1.
REQ-007 A start asserted while busy SHALL be ignored.
REQ-008 The FSM SHALL use the states IDLE, RD, CAP, OUT and FIN.
- IDLE to RD on start.
- RD to CAP after one cycle.
- CAP to OUT after one cycle.
- OUT to RD on handshake when pixels remain.
- OUT to FIN on handshake of the last pixel.
- FIN to IDLE after one cycle.
REQ-009 In RD, the block SHALL assert buf_rd_en for exactly one cycle with buf_rd_addr = oy*input_w + ox (strided buffer layout).
REQ-010 buf_rd_data SHALL be valid in the cycle after RD and SHALL be sampled in CAP.
REQ-011 Pixels SHALL be visited in raster order: ox from 0 to OUT_W-1 (inner loop), then oy from 0 to OUT_H-1.
REQ-012 out_addr SHALL equal oy*OUT_W + ox (dense layout).
REQ-013 Each channel SHALL be requantised as follows, in order:
- if relu_en and p<0, then p = 0;
- if shift>0, then p = (p + 2^(shift-1)) >>> shift (arithmetic shift, round half up), computed in ACC_WIDTH+1 bits;
- saturate to [-128, 127].
REQ-014 out_valid SHALL be asserted throughout OUT, and out_data and out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 A handshake SHALL occur only in a cycle where out_valid=1 and out_ready=1, and each pixel SHALL be presented exactly once.
REQ-016 out_ready SHALL be ignored outside OUT, and out_valid SHALL be 0 outside OUT.
REQ-017 busy SHALL be 1 in the RD, CAP, OUT and FIN states, and 0 in IDLE.
REQ-018 done SHALL pulse for exactly one cycle, in FIN.
REQ-019 If kernel_h=0, kernel_w=0, kernel_h>input_h or kernel_w>input_w, the block SHALL go IDLE to FIN directly, issuing no reads and no output beats.
REQ-020 Minimum throughput SHALL be one pixel per 3 cycles when out_ready is held at 1.
REQ-021 The block SHALL never issue a read with an address of input_w*input_h or above.

Reset
REQ-022 While rst_n=0, the block SHALL immediately force the state to IDLE and drive the following outputs:
- busy=0, done=0, buf_rd_en=0, out_valid=0;
- buf_rd_addr=0, out_addr=0, out_data=0;
- all latched configuration and counters to 0.
REQ-023 A reset asserted mid-drain SHALL abandon the drain without a done pulse, and the next start SHALL begin again at pixel (0,0).

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- 8x8 input, 3x3 kernel, out_ready held 1 -> 36 beats; out_addr 0..35; buffer addresses 0..5, 8..13, ..., 40..45; one done pulse; total duration 36*3+2 cycles.
- shift=1, relu_en=0, channel psums {300, -5, 3, -300} -> out_data channels {127, -2, 2, -128}.
- relu_en=1, shift=0, psums {-7, 42} -> {0, 42}.
- out_ready toggled pseudo-randomly -> out_data and out_addr stable while stalled; no beat dropped or duplicated; all 36 beats in order.
- kernel_h=9 with input_h=8 -> no buf_rd_en and no out_valid; done pulses 2 cycles after start.
- rst_n pulsed low during beat 10 -> all outputs 0 immediately; no done; restart yields beats again from out_addr 0.
